// File: rtl/fl_pipe_multi_if.sv
// FrameLink port bundle: one word (data, rem, four active-low delimiters) plus the src/dst ready handshake.
interface fl_pipe_multi_if #(
  parameter int DATA_WIDTH = 64
);
  // An 8-bit bus has no meaningful REM; keep one bit so the port never collapses to zero width.
  localparam int REM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

  logic [DATA_WIDTH-1:0] data;
  logic [REM_WIDTH-1:0]  rem;
  logic                  sof_n;
  logic                  eof_n;
  logic                  sop_n;
  logic                  eop_n;
  logic                  src_rdy_n;
  logic                  dst_rdy_n;

  modport master (
    output data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
    input  dst_rdy_n
  );

  modport slave (
    input  data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
    output dst_rdy_n
  );
endinterface

// File: rtl/fl_pipe_multi.sv
// STAGES cascaded 2-entry skid-buffer stages between a FrameLink RX and TX port (STAGES=0 is wires).
// Defining FL_PIPE_MULTI_STATS_EN adds saturating TX word/frame counters with a synchronous clear.
module fl_pipe_multi #(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  fl_pipe_multi_if.slave  rx,
  fl_pipe_multi_if.master tx
`ifdef FL_PIPE_MULTI_STATS_EN
  ,
  input  logic            STAT_CLR,
  output logic [31:0]     STAT_WORDS,
  output logic [31:0]     STAT_FRAMES
`endif
);

  localparam int REM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
  localparam int WORD_W    = DATA_WIDTH + REM_WIDTH + 4;
  localparam logic [WORD_W-1:0] RST_WORD = {{(DATA_WIDTH + REM_WIDTH){1'b0}}, 4'b1111};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } stage_state_e;

  generate
    if (STAGES == 0) begin : g_wire
      assign tx.data      = rx.data;
      assign tx.rem       = rx.rem;
      assign tx.sof_n     = rx.sof_n;
      assign tx.eof_n     = rx.eof_n;
      assign tx.sop_n     = rx.sop_n;
      assign tx.eop_n     = rx.eop_n;
      assign tx.src_rdy_n = rx.src_rdy_n;
      assign rx.dst_rdy_n = tx.dst_rdy_n;
    end else begin : g_pipe
      // Index 0 is the RX side, index STAGES the TX side; stage i sits between i and i+1.
      logic [STAGES:0]             chain_valid;
      logic [STAGES:0]             chain_rdy_n;
      logic [STAGES:0][WORD_W-1:0] chain_word;

      assign chain_valid[0]      = ~rx.src_rdy_n;
      assign chain_word[0]       = {rx.data, rx.rem, rx.sof_n, rx.eof_n, rx.sop_n, rx.eop_n};
      assign rx.dst_rdy_n        = chain_rdy_n[0];
      assign chain_rdy_n[STAGES] = tx.dst_rdy_n;
      assign tx.src_rdy_n        = ~chain_valid[STAGES];
      assign {tx.data, tx.rem, tx.sof_n, tx.eof_n, tx.sop_n, tx.eop_n} = chain_word[STAGES];

      for (genvar i = 0; i < STAGES; i++) begin : g_stage
        stage_state_e      state_q;
        stage_state_e      state_d;
        logic [WORD_W-1:0] main_q;
        logic [WORD_W-1:0] main_d;
        logic [WORD_W-1:0] skid_q;
        logic [WORD_W-1:0] skid_d;
        logic              rdy_n_q;
        logic              rdy_n_d;
        logic              in_xfer;
        logic              out_xfer;

        // rdy_n_q is high while in reset and in TWO, so it alone gates acceptance.
        always_comb begin
          in_xfer  = chain_valid[i] & ~rdy_n_q;
          out_xfer = (state_q != ST_EMPTY) & ~chain_rdy_n[i+1];
          state_d  = state_q;
          main_d   = main_q;
          skid_d   = skid_q;
          unique case (state_q)
            ST_EMPTY: begin
              if (in_xfer) begin
                state_d = ST_ONE;
                main_d  = chain_word[i];
              end
            end
            ST_ONE: begin
              if (in_xfer && !out_xfer) begin
                state_d = ST_TWO;
                skid_d  = chain_word[i];
              end else if (out_xfer && !in_xfer) begin
                state_d = ST_EMPTY;
              end else if (in_xfer && out_xfer) begin
                main_d  = chain_word[i];
              end
            end
            ST_TWO: begin
              if (out_xfer) begin
                state_d = ST_ONE;
                main_d  = skid_q;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
          rdy_n_d = (state_d == ST_TWO);
        end

        always_ff @(posedge CLK or negedge RESET_N) begin
          if (!RESET_N) begin
            state_q <= ST_EMPTY;
            main_q  <= RST_WORD;
            skid_q  <= RST_WORD;
            rdy_n_q <= 1'b1;
          end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_n_q <= rdy_n_d;
          end
        end

        assign chain_valid[i+1] = (state_q != ST_EMPTY);
        assign chain_word[i+1]  = main_q;
        assign chain_rdy_n[i]   = rdy_n_q;
      end
    end
  endgenerate

`ifdef FL_PIPE_MULTI_STATS_EN
  logic        tx_xfer;
  logic        tx_eof_xfer;
  logic [31:0] words_q;
  logic [31:0] words_d;
  logic [31:0] frames_q;
  logic [31:0] frames_d;

  // A clear coinciding with an event keeps that event, so the counter restarts at 1.
  function automatic logic [31:0] next_count(input logic [31:0] cnt, input logic clr,
                                             input logic ev);
    if (clr) return {31'd0, ev};
    if (ev && (cnt != 32'hFFFF_FFFF)) return cnt + 32'd1;
    return cnt;
  endfunction

  always_comb begin
    tx_xfer     = ~tx.src_rdy_n & ~tx.dst_rdy_n;
    tx_eof_xfer = tx_xfer & ~tx.eof_n;
    words_d     = next_count(words_q, STAT_CLR, tx_xfer);
    frames_d    = next_count(frames_q, STAT_CLR, tx_eof_xfer);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      words_q  <= 32'd0;
      frames_q <= 32'd0;
    end else begin
      words_q  <= words_d;
      frames_q <= frames_d;
    end
  end

  assign STAT_WORDS  = words_q;
  assign STAT_FRAMES = frames_q;
`endif

endmodule

// File: tb/tb_fl_pipe_multi.sv
// Scoreboard bench for fl_pipe_multi: framed random traffic against a FIFO reference model,
// plus a STAGES=0 mirror check; counter checks are added when FL_PIPE_MULTI_STATS_EN is defined.
`timescale 1ns/1ps
module tb_fl_pipe_multi;
  localparam int DW  = 64;
  localparam int NST = 3;
  localparam int RW  = $clog2(DW / 8);
  localparam int WW  = DW + RW + 4;
  localparam logic [WW-1:0] RST_W = {{(DW + RW){1'b0}}, 4'b1111};

  typedef struct {
    logic [WW-1:0] word;
    int            cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  int cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   check_lat = 1'b0;
  int   tx_mode = 1;

  fl_pipe_multi_if #(.DATA_WIDTH(DW)) rx_if ();
  fl_pipe_multi_if #(.DATA_WIDTH(DW)) tx_if ();
  fl_pipe_multi_if #(.DATA_WIDTH(DW)) rx0_if ();
  fl_pipe_multi_if #(.DATA_WIDTH(DW)) tx0_if ();

`ifdef FL_PIPE_MULTI_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_words;
  logic [31:0] stat_frames;
  logic [31:0] stat0_words;
  logic [31:0] stat0_frames;
`endif

  fl_pipe_multi #(.DATA_WIDTH(DW), .STAGES(NST)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .rx          (rx_if),
    .tx          (tx_if)
`ifdef FL_PIPE_MULTI_STATS_EN
    ,
    .STAT_CLR    (stat_clr),
    .STAT_WORDS  (stat_words),
    .STAT_FRAMES (stat_frames)
`endif
  );

  fl_pipe_multi #(.DATA_WIDTH(DW), .STAGES(0)) dut0 (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .rx          (rx0_if),
    .tx          (tx0_if)
`ifdef FL_PIPE_MULTI_STATS_EN
    ,
    .STAT_CLR    (1'b0),
    .STAT_WORDS  (stat0_words),
    .STAT_FRAMES (stat0_frames)
`endif
  );

  logic [WW-1:0] tx_word;
  logic [WW-1:0] rx0_word;
  logic [WW-1:0] tx0_word;
  assign tx_word  = {tx_if.data, tx_if.rem, tx_if.sof_n, tx_if.eof_n, tx_if.sop_n, tx_if.eop_n};
  assign rx0_word = {rx0_if.data, rx0_if.rem, rx0_if.sof_n, rx0_if.eof_n, rx0_if.sop_n, rx0_if.eop_n};
  assign tx0_word = {tx0_if.data, tx0_if.rem, tx0_if.sof_n, tx0_if.eof_n, tx0_if.sop_n, tx0_if.eop_n};

  task automatic check_output(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at t=%0t", name, $time);
  endtask

  function automatic logic [WW-1:0] make_word(input bit sof, input bit eof);
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic          sop_n;
    logic          eop_n;
    d     = {$urandom, $urandom};
    r     = RW'($urandom);
    sop_n = sof ? 1'b0 : 1'($urandom_range(0, 1));
    eop_n = eof ? 1'b0 : 1'($urandom_range(0, 1));
    return {d, r, ~sof, ~eof, sop_n, eop_n};
  endfunction

  // TX sink: always ready, always blocked, or a fair coin each cycle.
  initial begin
    tx_if.dst_rdy_n = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (tx_mode)
        0:       tx_if.dst_rdy_n = 1'b0;
        1:       tx_if.dst_rdy_n = 1'b1;
        default: tx_if.dst_rdy_n = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the reference FIFO on every TX transfer and checks hold-stability while blocked.
  initial begin : monitor
    logic [WW-1:0] held_word;
    bit            held;
    exp_t          e;
    held = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET_N && !tx_if.src_rdy_n) begin
        if (held) check_output("tx_stable", tx_word, held_word);
        if (tx_if.dst_rdy_n) begin
          held      = 1'b1;
          held_word = tx_word;
        end else begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_unexpected: got %h expected no word (t=%0t)", tx_word, $time);
          end else begin
            e = exp_q.pop_front();
            check_output("tx_word", tx_word, e.word);
            if (check_lat) check_output("latency", WW'(cycle - e.cyc), WW'(NST));
          end
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic [WW-1:0] w);
    int waited;
    waited = 0;
    {rx_if.data, rx_if.rem, rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} = w;
    rx_if.src_rdy_n = 1'b0;
    while (1) begin
      @(negedge CLK);
      if (!rx_if.dst_rdy_n) begin
        exp_q.push_back('{word: w, cyc: cycle});
        break;
      end
      waited++;
      if (waited > 2000) begin
        report_timeout("rx_accept");
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle();
    rx_if.src_rdy_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle_cycle();
      apply_stimulus(make_word(i == 0, i == len - 1));
    end
    rx_if.src_rdy_n = 1'b1;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    rx_if.src_rdy_n = 1'b1;
    while (1) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && tx_if.src_rdy_n) break;
      waited++;
      if (waited > 5000) begin
        report_timeout("drain");
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic mirror_check();
    {rx0_if.data, rx0_if.rem, rx0_if.sof_n, rx0_if.eof_n, rx0_if.sop_n, rx0_if.eop_n} =
        {$urandom, $urandom, WW'($urandom)};
    rx0_if.src_rdy_n = 1'($urandom_range(0, 1));
    tx0_if.dst_rdy_n = 1'($urandom_range(0, 1));
    #1;
    check_output("s0_word", tx0_word, rx0_word);
    check_output("s0_src", WW'(tx0_if.src_rdy_n), WW'(rx0_if.src_rdy_n));
    check_output("s0_dst", WW'(rx0_if.dst_rdy_n), WW'(tx0_if.dst_rdy_n));
  endtask

  initial begin : watchdog
    #(900_000);
    $display("[TB] FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int accepted;
    rx_if.src_rdy_n = 1'b1;
    {rx_if.data, rx_if.rem, rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} = RST_W;

    // Reset state, and the zero-stage instance ignoring reset.
    #2 RESET_N = 1'b0;
    #1;
    check_output("rst_tx_src", WW'(tx_if.src_rdy_n), WW'(1));
    check_output("rst_rx_dst", WW'(rx_if.dst_rdy_n), WW'(1));
    check_output("rst_tx_word", tx_word, RST_W);
    for (int i = 0; i < 4; i++) mirror_check();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check_output("rel_rx_dst_before_edge", WW'(rx_if.dst_rdy_n), WW'(1));
    @(posedge CLK);
    #1;
    check_output("rel_rx_dst_after_edge", WW'(rx_if.dst_rdy_n), WW'(0));

    // Back-to-back 10-word frame with the sink always ready: fixed latency.
    tx_mode = 0;
    @(posedge CLK);
    #1;
    check_lat = 1'b1;
    send_frame(10, 1'b0);
    wait_drain();
    check_lat = 1'b0;

    // Sink blocked, source always valid: capacity is exactly 2*NST.
    tx_mode = 1;
    repeat (2) @(posedge CLK);
    #1;
    accepted = 0;
    for (int k = 0; k < 30; k++) begin
      {rx_if.data, rx_if.rem, rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n} =
          make_word(accepted == 0, 1'b0);
      rx_if.src_rdy_n = 1'b0;
      @(negedge CLK);
      if (!rx_if.dst_rdy_n) begin
        exp_q.push_back('{word: tx_word ^ tx_word ^
                          {rx_if.data, rx_if.rem, rx_if.sof_n, rx_if.eof_n, rx_if.sop_n, rx_if.eop_n},
                          cyc: cycle});
        accepted++;
      end
      @(posedge CLK);
      #1;
    end
    check_output("capacity", WW'(accepted), WW'(2 * NST));
    check_output("full_rx_dst", WW'(rx_if.dst_rdy_n), WW'(1));
    tx_mode = 0;
    wait_drain();

    // Random valid/ready on both sides over many frames.
    tx_mode = 2;
    for (int f = 0; f < 300; f++) send_frame($urandom_range(1, 40), 1'b1);
    wait_drain();

    // Asynchronous reset with 4 words buffered; nothing stale afterwards.
    tx_mode = 1;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) apply_stimulus(make_word(i == 0, 1'b0));
    rx_if.src_rdy_n = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check_output("buffered_tx_src", WW'(tx_if.src_rdy_n), WW'(0));
    #2 RESET_N = 1'b0;
    #1;
    check_output("async_tx_src", WW'(tx_if.src_rdy_n), WW'(1));
    check_output("async_rx_dst", WW'(rx_if.dst_rdy_n), WW'(1));
    check_output("async_tx_word", tx_word, RST_W);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check_output("post_rst_rx_dst", WW'(rx_if.dst_rdy_n), WW'(0));
    tx_mode = 0;
    send_frame(3, 1'b0);
    wait_drain();

    for (int i = 0; i < 8; i++) mirror_check();

`ifdef FL_PIPE_MULTI_STATS_EN
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int f = 0; f < 5; f++) send_frame(4, 1'b0);
    wait_drain();
    repeat (2) @(posedge CLK);
    #1;
    check_output("stat_words", WW'(stat_words), WW'(20));
    check_output("stat_frames", WW'(stat_frames), WW'(5));
    tx_mode = 1;
    repeat (2) @(posedge CLK);
    #1;
    send_frame(1, 1'b0);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    tx_mode = 0;
    @(posedge CLK);
    #1;
    stat_clr = 1'b1;
    @(posedge CLK);
    #1;
    stat_clr = 1'b0;
    check_output("clr_words", WW'(stat_words), WW'(1));
    check_output("clr_frames", WW'(stat_frames), WW'(1));
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
